// File: rtl/data_memory_pkg.sv
// Shared constants, state encoding and address helpers for the line-wide
// main-memory model behind the data cache.
package data_memory_pkg;

  localparam int LINE_WIDTH      = 256;
  localparam int DEPTH           = 512;
  localparam int ADDR_WIDTH      = 32;
  localparam int INDEX_WIDTH     = 9;
  localparam int OFFSET_BITS     = 5;
  localparam int LATENCY_DEFAULT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Byte offset within a line and everything above the index are ignored,
  // so addresses wrap modulo DEPTH lines.
  function automatic logic [INDEX_WIDTH-1:0] line_index(
    input logic [ADDR_WIDTH-1:0] addr
  );
    return addr[OFFSET_BITS +: INDEX_WIDTH];
  endfunction

endpackage

// File: rtl/data_memory.sv
// Main-memory model: one line-wide read or write at a time, completed after a
// fixed latency with a single-cycle acknowledge carrying the read data.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] data_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  output logic                  ack_o,
  output logic [LINE_WIDTH-1:0] data_o
);

  localparam int                CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LATENCY - 1);

  // Handshake: a request is accepted on any rising edge in IDLE with
  // enable_i high; inputs are then ignored until ack_o has pulsed for one
  // cycle, and data_o is meaningful only while ack_o is high.

  logic [LINE_WIDTH-1:0] memory [0:DEPTH-1];

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_next;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [LINE_WIDTH-1:0] r_data;
  logic                  r_write;
  logic                  w_accept;
  logic                  w_done;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
          w_count_next = '0;
        end
      end
      WAIT: begin
        if (r_count == LAST) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_comb begin
    ack_o  = w_done;
    data_o = w_done ? memory[r_idx] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_idx   <= line_index(addr_i);
        r_data  <= data_i;
        r_write <= write_i;
      end
    end
  end

  // Plain always so benches may preload or flush lines hierarchically;
  // contents intentionally survive reset.
  always @(posedge clk_i) begin
    if (w_done && r_write) begin
      memory[r_idx] <= r_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: table of directed transactions, hand-written
// back-to-back and reset sequences, then random traffic against a line model.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int LAT = 10;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic         ack_o;
  logic [255:0] data_o;

  int tests = 0;
  int fails = 0;

  logic [255:0] model_mem [512];

  data_memory #(.LATENCY(LAT)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    bit           perturb;
    logic [255:0] exp_data;
    string        name;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [255:0] pre(input int i);
    logic [255:0] v;
    v = '0;
    if (i == 0) v = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    else if (i == 16) v = {4{64'h0123_4567_89AB_CDEF}};
    else if (i == 32) begin
      for (int h = 0; h < 16; h++) v[255 - 16*h -: 16] = 16'(h * 16'h1001);
    end else begin
      for (int w = 0; w < 8; w++) v[32*w +: 32] = (32'(i) * 32'h9E37_79B9) ^ (32'(w) << 24) ^ 32'h1234_5678;
    end
    return v;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request pulse; monitors the whole window and checks ack timing,
  // ack data, idle data_o, write ordering and the final line contents.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                         input bit perturb, input logic [255:0] exp_data, input string nm);
    int idx, ack_n, ack_c, nz, early;
    logic [255:0] old, got, exp_after;
    idx = idx_of(addr);
    old = model_mem[idx];
    exp_after = wr ? wd : old;
    ack_n = 0; ack_c = -1; nz = 0; early = 0; got = '0;
    @(negedge clk_i);
    enable_i = 1'b1; write_i = wr; addr_i = addr; data_i = wd;
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    for (int c = 1; c <= LAT + 4; c++) begin
      @(negedge clk_i);
      if (perturb && c == 3) begin
        addr_i = 32'h0; write_i = ~wr; data_i = ~wd;
      end
      if (ack_o) begin
        ack_n++;
        if (ack_c < 0) begin ack_c = c; got = data_o; end
      end else if (data_o != '0) nz++;
      if (c <= LAT && dut.memory[idx] !== old) early++;
    end
    chk({nm, "_ack_count"}, 256'(ack_n), 256'(1));
    chk({nm, "_ack_cycle"}, 256'(ack_c), 256'(LAT));
    chk({nm, "_ack_data"}, got, exp_data);
    chk({nm, "_idle_data_nonzero"}, 256'(nz), 256'(0));
    chk({nm, "_early_write"}, 256'(early), 256'(0));
    chk({nm, "_line_after"}, dut.memory[idx], exp_after);
    model_mem[idx] = exp_after;
  endtask

  task automatic back_to_back();
    int ack_n, c1, c2;
    logic [255:0] d1, d2;
    ack_n = 0; c1 = -1; c2 = -1; d1 = '0; d2 = '0;
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0020; data_i = '0;
    @(posedge clk_i);
    #1 addr_i = 32'h0040;
    for (int c = 1; c <= 2 * LAT + 6; c++) begin
      @(negedge clk_i);
      if (ack_o) begin
        ack_n++;
        if (c1 < 0) begin c1 = c; d1 = data_o; end
        else if (c2 < 0) begin c2 = c; d2 = data_o; end
      end
      if (c == 12) enable_i = 1'b0;
    end
    chk("b2b_ack_count", 256'(ack_n), 256'(2));
    chk("b2b_first_cycle", 256'(c1), 256'(LAT));
    chk("b2b_spacing", 256'(c2 - c1), 256'(LAT + 1));
    chk("b2b_data1", d1, model_mem[1]);
    chk("b2b_data2", d2, model_mem[2]);
  endtask

  task automatic reset_mid_wait();
    int ack_n;
    ack_n = 0;
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0400; data_i = {8{32'hDEAD_BEEF}};
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      if (ack_o) ack_n++;
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_ack_low", 256'(ack_o), 256'(0));
    chk("rst_data_zero", data_o, '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk_i);
      if (ack_o) ack_n++;
    end
    chk("rst_no_ack", 256'(ack_n), 256'(0));
    chk("rst_line32_kept", dut.memory[32], pre(32));
    run_txn(1'b0, 32'h0400, '0, 1'b0, pre(32), "after_rst");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      model_mem[i] = pre(i);
      dut.memory[i] = pre(i);
    end

    vecs[0] = '{1'b0, 32'h0000_0000, '0,               1'b0, pre(0),          "read0"};
    vecs[1] = '{1'b1, 32'h0000_0220, {16{16'hECFA}},   1'b0, pre(17),         "write17"};
    vecs[2] = '{1'b0, 32'h0000_0220, '0,               1'b0, {16{16'hECFA}},  "readback17"};
    vecs[3] = '{1'b0, 32'h0000_401F, '0,               1'b0, pre(0),          "alias0"};
    vecs[4] = '{1'b0, 32'h0000_0200, '0,               1'b1, pre(16),         "midchange16"};
    vecs[5] = '{1'b1, 32'h0000_3FE0, {8{32'h5A5A_0511}}, 1'b0, pre(511),      "write511"};
    vecs[6] = '{1'b0, 32'h0000_7FE0, '0,               1'b0, {8{32'h5A5A_0511}}, "alias511"};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF, '0,               1'b0, {8{32'h5A5A_0511}}, "allones511"};

    // Reset state
    #2;
    chk("reset_ack", 256'(ack_o), 256'(0));
    chk("reset_data", data_o, '0);
    chk("reset_state", 256'(dut.r_state), 256'(IDLE));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].perturb, vecs[v].exp_data, vecs[v].name);

    back_to_back();
    reset_mid_wait();

    for (int n = 0; n < 40; n++) begin
      logic [31:0]  a;
      logic [255:0] d;
      bit           w;
      a = $urandom;
      if (n % 3 == 0) a[13:5] = 9'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      run_txn(w, a, d, 1'($urandom_range(0, 1)), model_mem[idx_of(a)], $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Off-chip main-memory model shared with the CPU's data cache over a line-wide request/acknowledge interface.
- Stores 512 lines of 256 bits (16 KB).
- Serves one read or write at a time with a fixed multi-cycle latency.
- Signals completion with a single-cycle acknowledge; read data is valid in that cycle.

Parameters:
- LINE_WIDTH, 256, bits per memory line / data bus width.
- DEPTH, 512, number of lines.
- ADDR_WIDTH, 32, byte-address width.
- LATENCY, 10, cycles from request acceptance to the acknowledge cycle inclusive; must be ≥ 2.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-high.
- addr_i  input  32  byte address; line index = addr_i[13:5]; bits [4:0] and [31:14] are ignored.
- data_i  input  256  write line data.
- enable_i  input  1  request valid.
- write_i  input  1  1 = write, 0 = read; qualified by enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line data; valid only while ack_o = 1.

Behaviour:
- Storage
  - Array named memory[0:DEPTH-1] of LINE_WIDTH bits.
  - Not cleared by reset; contents persist across rst_i.
  - Must be hierarchically writable by benches for preload and cache flush.
- FSM states: IDLE, WAIT. Cycle counter width = clog2(LATENCY).
- Reset (async, rst_i = 1)
  - State = IDLE, counter = 0, ack_o = 0, data_o = 0.
  - Latched request registers cleared.
- IDLE
  - If enable_i = 1 at a rising edge: latch addr_i[13:5], data_i and write_i; go to WAIT; counter = 0.
  - Otherwise stay in IDLE.
- WAIT
  - Counter increments each edge.
  - ack_o = 1 combinationally while counter == LATENCY-1. Net effect: ack is high during the LATENCY-th cycle after the accepting edge.
  - At the edge ending the ack cycle: state returns to IDLE and counter clears to 0.
  - If the latched request is a write, memory[idx] <= latched data at that same edge. Memory is unchanged before then.
- Read data
  - data_o = memory[latched idx] during the ack cycle; 0 otherwise.
  - A write returns the old line contents on data_o during its ack cycle (don't-care to the cache).
- enable_i / write_i / addr_i / data_i are ignored while in WAIT. Changes mid-transaction do not abort or alter it.
- Back-to-back requests
  - No acceptance in the ack cycle itself.
  - A request held high after ack is accepted on the first edge in IDLE, giving a minimum of LATENCY+1 cycles between accept edges.
- Address wrap: indices are modulo DEPTH, so 0x4000 aliases line 0.
- Reset asserted mid-WAIT: transaction is dropped, no write occurs, no ack is produced.

Decomposition:
- Package data_memory_pkg: LINE_WIDTH, DEPTH, INDEX_WIDTH = 9, OFFSET_BITS = 5, LATENCY default, state enum {IDLE, WAIT}.
- Single module; no sub-module needed. The latency counter is inline.

Test Plan:
- Read:
  - Preload memory[0] = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF.
  - Pulse enable_i = 1, write_i = 0, addr_i = 0x0000 for one cycle.
  - Required: ack_o high for exactly one cycle, the 10th after acceptance, with data_o equal to that value. data_o = 0 in all other cycles.
- Write:
  - enable_i = 1, write_i = 1, addr_i = 0x0220, data_i = 256'hECFA repeated.
  - Required: memory[17] unchanged through the ack cycle; equals the new data after the ack edge. Exactly one ack.
- Alias and ignored bits:
  - Read addr_i = 0x401F.
  - Required: returns memory[0]; ack timing as for any read.
- Back-to-back with held enable:
  - Hold enable_i high with read 0x0020 then read 0x0040.
  - Required: two single-cycle acks 11 cycles apart, with data memory[1] then memory[2].
- Input change mid-transaction:
  - Accept a read of 0x0200, then change addr_i to 0x0000 in cycle 3.
  - Required: data_o at ack = memory[16] (0123_4567_89AB_CDEF… pattern).
- Reset mid-WAIT:
  - Start a write to 0x0400, assert rst_i in cycle 5.
  - Required: ack_o = 0 immediately; memory[32] keeps its preload value (0000_1001_2002_…_F00F). The next request completes normally in 10 cycles.
